msk_lbox_serial_ctrl: RTL

Sequential feeder/collector for the masked dual-L-box unit of the Clyde datapath. It latches a full masked state of d·Nbits share bits and streams it, one bundle per cycle, to the combinational L-box unit. It captures each returned bundle and reassembles the full processed state. With 2**PDLBOX bundles, one L-box layer takes 2**PDLBOX cycles. The block only moves share bits: it never combines shares, so it adds no masking-order loss to the PINI L-box.

---
 rtl/msk_lbox_serial_ctrl_if.sv | 26 ++
 rtl/msk_lbox_serial_ctrl.sv | 92 +++++++++
 2 files changed

// File: rtl/msk_lbox_serial_ctrl_if.sv
// Bundle of the layer request/response and L-box bundle signals around the serial controller.
// The master side is the environment (requester plus L-box unit); the slave side is the controller.
interface msk_lbox_serial_ctrl_if #(
  parameter int W    = 256,
  parameter int SIZE = 256
) ();
  logic            start;
  logic            inverse_in;
  logic [W-1:0]    state_in;
  logic            busy;
  logic            done;
  logic [W-1:0]    state_out;
  logic [SIZE-1:0] lb_bundle_to;
  logic [SIZE-1:0] lb_bundle_from;
  logic            lb_inverse;

  modport master (
    output start, inverse_in, state_in, lb_bundle_from,
    input  busy, done, state_out, lb_bundle_to, lb_inverse
  );

  modport slave (
    input  start, inverse_in, state_in, lb_bundle_from,
    output busy, done, state_out, lb_bundle_to, lb_inverse
  );
endinterface

// File: rtl/msk_lbox_serial_ctrl.sv
// Streams a latched masked state bundle-by-bundle through the combinational dual L-box
// and reassembles the result in place; only moves share bits, never combines them.
//
// state | meaning
// IDLE  | waiting for start; R holds the last result
// RUN   | one bundle per cycle leaves R[SIZE-1:0], processed bundle enters at the top
module msk_lbox_serial_ctrl #(
  parameter int PDLBOX = 0,
  parameter int Nbits  = 128,
  parameter int d      = 2,
  localparam int AM    = 1 << PDLBOX,
  localparam int W     = d * Nbits,
  localparam int SIZE  = W / AM,
  localparam int CW    = (PDLBOX + 1 < 1) ? 1 : PDLBOX + 1
) (
  input  logic clk,
  input  logic rst,
  msk_lbox_serial_ctrl_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [W-1:0]    r_q;
  logic [W-1:0]    r_shift;
  logic            done_q, done_nxt;
  logic            inv_q;
  logic            load, shift;

  // With a single bundle the whole register is replaced by the L-box output.
  generate
    if (AM == 1) begin : g_single
      assign r_shift = bus.lb_bundle_from;
    end else begin : g_multi
      assign r_shift = {bus.lb_bundle_from, r_q[W-1:SIZE]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
      inv_q  <= 1'b0;
      r_q    <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      done_q <= done_nxt;
      if (load) begin
        r_q   <= bus.state_in;
        inv_q <= bus.inverse_in;
      end else if (shift) begin
        r_q <= r_shift;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        shift   = 1'b1;
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(AM - 1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy         = (state == RUN);
  assign bus.done         = done_q;
  assign bus.state_out    = r_q;
  assign bus.lb_bundle_to = r_q[SIZE-1:0];
  assign bus.lb_inverse   = inv_q;

endmodule
